signedmul_arbiter: RTL

Round-robin scheduler that shares one Q4.12 signed fixed-point multiplier among `NUM_REQ` requesters, such as the four LSTM gate datapaths. It accepts at most one operand pair per cycle through a valid/ready handshake and pushes it through a two-stage registered multiply pipeline. It returns each product tagged one-hot to the requester that issued it. It sits between the gate controllers and the shared multiply resource in each LSTM cell.

---
 rtl/signedmul_pkg.sv | 33 +++
 rtl/signedmul_core.sv | 99 +++++++++
 rtl/signedmul_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/signedmul_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// Q4.12 shared-multiplier arbiter.
package signedmul_pkg;

  localparam int unsigned SM_DATA_W = 16;
  localparam int unsigned SM_FRAC_W = 12;
  localparam int unsigned RR_MAX    = 8;

  typedef logic signed [SM_DATA_W-1:0] q4_12_t;

  localparam q4_12_t Q_MAX = 16'sh7FFF;
  localparam q4_12_t Q_MIN = 16'sh8000;

  // First valid requester after `last`, wrapping modulo n; one-hot result.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                input logic [2:0]        last,
                                                input int unsigned       n);
    logic [RR_MAX-1:0] grant;
    logic              found;
    logic [2:0]        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = 3'((32'(last) + k) % n);
      if (k <= n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/signedmul_core.sv
// Two-stage sign/magnitude Q4.12 multiply pipeline with a shared stall enable.
// Define SIGNEDMUL_ARB_SAT_EN to saturate overflowing products instead of wrapping.
module signedmul_core
  import signedmul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = SM_DATA_W,
  parameter int unsigned FRAC_W  = SM_FRAC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [NUM_REQ-1:0] i_tag,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_tag,
  output logic [DATA_W-1:0]  o_data_c,
  output logic               o_busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned MSB    = FRAC_W + DATA_W - 1;

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [DATA_W-1:0]  r_s1_mag_a;
  logic [DATA_W-1:0]  r_s1_mag_b;
  logic [NUM_REQ-1:0] r_s1_tag;
  logic               r_s2_valid;
  logic               r_s2_sign;
  logic [PROD_W-1:0]  r_s2_mag;
  logic [NUM_REQ-1:0] r_s2_tag;

  logic [DATA_W-1:0]  w_mag_a;
  logic [DATA_W-1:0]  w_mag_b;
  logic [DATA_W-1:0]  w_q;
  logic [DATA_W-1:0]  w_q_neg;
  logic [DATA_W-1:0]  w_res;
  logic               w_unused_bits;

  // Unsigned negation keeps the most negative input as a full-scale magnitude.
  assign w_mag_a = i_a[DATA_W-1] ? (~i_a + DATA_W'(1)) : i_a;
  assign w_mag_b = i_b[DATA_W-1] ? (~i_b + DATA_W'(1)) : i_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag_a <= '0;
      r_s1_mag_b <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_tag   <= '0;
    end else if (i_en) begin
      r_s1_valid <= i_valid;
      r_s1_sign  <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
      r_s1_mag_a <= w_mag_a;
      r_s1_mag_b <= w_mag_b;
      r_s1_tag   <= i_tag;
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_mag   <= PROD_W'(r_s1_mag_a) * PROD_W'(r_s1_mag_b);
      r_s2_tag   <= r_s1_tag;
    end
  end

  // Truncate toward zero on the magnitude, then restore the sign.
  assign w_q     = r_s2_mag[MSB:FRAC_W];
  assign w_q_neg = ~w_q + DATA_W'(1);

`ifdef SIGNEDMUL_ARB_SAT_EN
  localparam logic [PROD_W-1:0] LIM = PROD_W'(1) << MSB;

  always_comb begin
    w_res = r_s2_sign ? w_q_neg : w_q;
    if (!r_s2_sign && (r_s2_mag >= LIM)) begin
      w_res = DATA_W'(Q_MAX);
    end else if (r_s2_sign && (r_s2_mag > LIM)) begin
      w_res = DATA_W'(Q_MIN);
    end
  end
`else
  always_comb begin
    w_res = r_s2_sign ? w_q_neg : w_q;
  end
`endif

  assign w_unused_bits = ^{r_s2_mag[PROD_W-1:MSB+1], r_s2_mag[FRAC_W-1:0]};

  assign o_valid  = r_s2_valid;
  assign o_tag    = r_s2_tag;
  assign o_data_c = w_res;
  assign o_busy   = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/signedmul_arbiter.sv
// Round-robin arbiter sharing one Q4.12 multiplier among NUM_REQ requesters.
// Define SIGNEDMUL_ARB_SAT_EN to saturate overflowing products instead of wrapping.
module signedmul_arbiter
  import signedmul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = SM_DATA_W,
  parameter int unsigned FRAC_W  = SM_FRAC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      resp_stall,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   r_last;
  logic [RR_MAX-1:0]  w_pick;
  logic               w_xfer;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic               w_core_valid;
  logic [NUM_REQ-1:0] w_core_tag;
  logic [DATA_W-1:0]  w_core_data;
  logic               w_core_busy;

  // Grant is combinational from req_valid and suppressed while stalled or in reset.
  assign w_pick    = rr_pick(RR_MAX'(req_valid), 3'(r_last), NUM_REQ);
  assign req_ready = (reset || resp_stall) ? '0 : w_pick[NUM_REQ-1:0];
  assign w_xfer    = |req_ready;

  always_comb begin
    w_idx = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        w_idx = IDX_W'(i);
        w_a   = req_a[i*DATA_W +: DATA_W];
        w_b   = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= IDX_W'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_last <= w_idx;
    end
  end

  signedmul_core #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_en     (!resp_stall),
    .i_valid  (w_xfer),
    .i_tag    (req_ready),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_valid  (w_core_valid),
    .o_tag    (w_core_tag),
    .o_data_c (w_core_data),
    .o_busy   (w_core_busy)
  );

  assign resp_valid = w_core_valid ? w_core_tag  : '0;
  assign resp_data  = w_core_valid ? w_core_data : '0;
  assign busy       = w_core_busy;

endmodule
